// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Signed overflow of a - b: operands of opposite sign and a result whose sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    sub_ovf = (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_bit.sv
// Combinational 1-bit full subtractor: d = ia - ib - bin, with borrow out.
module sub_bit (
  input  logic ia,
  input  logic ib,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ia ^ ib ^ bin;
  assign bout = (~ia & ib) | (~ia & bin) | (ib & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow; start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             br_nxt_s;
  logic             accept_s;
  logic             last_s;

  sub_bit u_sub_bit (
    .ia   (a_r[0]),
    .ib   (b_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (br_nxt_s)
  );

  assign res_nxt_s = {d_s, res_r[WIDTH-1:1]};

  // Handshake qualifiers: new work is only taken when not running.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == S_RUN) begin
      last_s = (cnt_r == CNT_LAST);
    end else begin
      last_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Controller state, handshake outputs and the serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == S_RUN);
      done    <= (state_nxt_s == S_DONE);
      if (accept_s) begin
        a_r     <= ia;
        b_r     <= ib;
        br_r    <= bin;
        a_msb_r <= ia[WIDTH-1];
        b_msb_r <= ib[WIDTH-1];
        res_r   <= {WIDTH{1'b0}};
        cnt_r   <= {CW{1'b0}};
      end else if (state_r == S_RUN) begin
        a_r   <= {1'b0, a_r[WIDTH-1:1]};
        b_r   <= {1'b0, b_r[WIDTH-1:1]};
        br_r  <= br_nxt_s;
        res_r <= res_nxt_s;
        if (!last_s) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Result and flags update only on the final bit, so they hold through RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= {WIDTH{1'b0}};
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (last_s) begin
      diff <= res_nxt_s;
      bout <= br_nxt_s;
      ovf  <= sub_ovf(a_msb_r, b_msb_r, res_nxt_s[WIDTH-1]);
      zero <= (res_nxt_s == {WIDTH{1'b0}});
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a random regression
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] ia = '0;
  logic [WIDTH-1:0] ib = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_diff;
  logic             exp_bout;
  logic             exp_ovf;
  logic             exp_zero;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ia    (ia),
    .ib    (ib),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; overflow from the operand/result sign rule.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    exp_diff = r[WIDTH-1:0];
    exp_bout = (r < 0);
    exp_zero = (exp_diff == '0);
    exp_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (exp_diff[WIDTH-1] != a[WIDTH-1]);
  endtask

  // Presents an operation now; it is accepted on the next rising edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    model(a, b, bi);
    start = 1'b1;
    ia = a;
    ib = b;
    bin = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    ia = WIDTH'($urandom);
    ib = WIDTH'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic finish(input string tag, input bit timing, input bit noise);
    int cycles;
    int busy_cnt;
    bit got;
    logic [WIDTH-1:0] held;
    cycles = 0;
    busy_cnt = 0;
    got = 1'b0;
    held = diff;
    while (!got && cycles < 20) begin
      if (busy) busy_cnt++;
      if (timing && cycles == 4) check_eq({tag, "_hold"}, 32'(diff), 32'(held));
      if (noise && cycles < 8) begin
        start = 1'($urandom);
        ia = WIDTH'($urandom);
        ib = WIDTH'($urandom);
        bin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, "_done"}, 32'(got), 32'd1);
    if (timing) begin
      check_eq({tag, "_lat"}, 32'(cycles), 32'(WIDTH));
      check_eq({tag, "_busy"}, 32'(busy_cnt), 32'(WIDTH));
    end
    check_eq({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check_eq({tag, "_bout"}, 32'(bout), 32'(exp_bout));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
  endtask

  task automatic quiet(input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic bi);
    launch(a, b, bi);
    finish(tag, 1'b1, 1'b0);
    quiet(tag);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_flags", {29'd0, bout, ovf, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op("t_5m3", 8'h05, 8'h03, 1'b0);
    op("t_3m5", 8'h03, 8'h05, 1'b0);
    op("t_0m0b", 8'h00, 8'h00, 1'b1);
    op("t_80m1", 8'h80, 8'h01, 1'b0);
    op("t_7fmff", 8'h7F, 8'hFF, 1'b0);
    op("t_5m5", 8'h05, 8'h05, 1'b0);

    // Start pulses during RUN must be ignored.
    launch(8'h5A, 8'h21, 1'b1);
    finish("t_noise", 1'b1, 1'b1);
    quiet("t_noise");

    // Back-to-back: start held in the DONE cycle.
    launch(8'h10, 8'h20, 1'b0);
    finish("t_b2b_a", 1'b1, 1'b0);
    launch(8'hC3, 8'h3C, 1'b1);
    finish("t_b2b_b", 1'b1, 1'b0);
    quiet("t_b2b_b");

    // Reset asserted on the 4th RUN edge.
    launch(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done), 32'd0);
    check_eq("mid_diff", 32'(diff), 32'd0);
    check_eq("mid_flags", {29'd0, bout, ovf, zero}, 32'd0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_eq("mid_nodone", 32'(pulses), 32'd0);
    op("t_after_rst", 8'h33, 8'h11, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      finish("rnd", 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
